// File: rtl/conv_sched.sv
// conv_sched: scheduler for a weight-stationary convolution array.
// One pass loads NW weight banks, then walks the kernel offsets (x, y)
// inside the output positions (X, Y), issuing shift/rewind strobes to the
// weight registers, and ends with a single-cycle finish pulse.
module conv_sched #(
    parameter int KSIZE = 3,
    parameter int OSIZE = 19,
    parameter int NW    = 16
) (
    input  logic       clk,
    input  logic       xrst,
    input  logic       start,
    input  logic       enable,
    output logic [3:0] w_raddr,
    output logic       w_load,
    output logic       shift_x,
    output logic       shift_y,
    output logic       rewind,
    output logic [1:0] x,
    output logic [1:0] y,
    output logic [4:0] X,
    output logic [4:0] Y,
    output logic       busy,
    output logic       finish
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] KMAX = 2'(KSIZE - 1);
    localparam logic [4:0] OMAX = 5'(OSIZE - 1);
    localparam logic [3:0] AMAX = 4'(NW - 1);

    logic [1:0] state;
    logic [1:0] nstate;
    logic       en_q;
    logic       armed;
    logic       issued_all;
    logic       nissued;
    logic       issue;
    logic [3:0] nraddr;
    logic [1:0] nx;
    logic [1:0] ny;
    logic [4:0] nX;
    logic [4:0] nY;

    // enable is registered: progress in a cycle is governed by the enable
    // sampled at the edge that opened it, so the registered strobes can be
    // computed one edge early and still describe the step taken at the end
    // of the cycle in which they are high.

    // Next-state and next-counter decode.
    always_comb begin
        nstate  = state;
        nraddr  = w_raddr;
        nissued = issued_all;
        issue   = 1'b0;
        nx      = x;
        ny      = y;
        nX      = X;
        nY      = Y;
        case (state)
            S_IDLE: begin
                if (start && armed) begin
                    nstate  = S_LOAD;
                    nraddr  = '0;
                    nissued = 1'b0;
                end
            end
            S_LOAD: begin
                if (issued_all) begin
                    // last w_load is being delivered this cycle
                    nstate  = S_RUN;
                    nraddr  = '0;
                    nissued = 1'b0;
                    nx      = '0;
                    ny      = '0;
                    nX      = '0;
                    nY      = '0;
                end else if (en_q) begin
                    issue = 1'b1;
                    if (w_raddr == AMAX) begin
                        nissued = 1'b1;
                    end else begin
                        nraddr = w_raddr + 4'd1;
                    end
                end
            end
            S_RUN: begin
                if (en_q) begin
                    if (x != KMAX) begin
                        nx = x + 2'd1;
                    end else begin
                        nx = '0;
                        if (y != KMAX) begin
                            ny = y + 2'd1;
                        end else begin
                            ny = '0;
                            if (X != OMAX) begin
                                nX = X + 5'd1;
                            end else begin
                                nX = '0;
                                if (Y != OMAX) begin
                                    nY = Y + 5'd1;
                                end else begin
                                    nY     = '0;
                                    nstate = S_DONE;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                nstate = S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

    // State, counters, address and the release/enable bookkeeping registers.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state      <= S_IDLE;
            w_raddr    <= '0;
            issued_all <= 1'b0;
            x          <= '0;
            y          <= '0;
            X          <= '0;
            Y          <= '0;
            en_q       <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= nstate;
            w_raddr    <= nraddr;
            issued_all <= nissued;
            x          <= nx;
            y          <= ny;
            X          <= nX;
            Y          <= nY;
            en_q       <= enable;
            armed      <= 1'b1;
        end
    end

    // Registered strobes: look ahead at the next cycle's counters and enable.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            w_load  <= 1'b0;
            shift_x <= 1'b0;
            shift_y <= 1'b0;
            rewind  <= 1'b0;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            w_load  <= issue;
            shift_x <= enable && (nstate == S_RUN) && (nx != KMAX);
            shift_y <= enable && (nstate == S_RUN) && (nx == KMAX) && (ny != KMAX);
            rewind  <= enable && (nstate == S_RUN) && (nx == KMAX) && (ny == KMAX);
            busy    <= (nstate != S_IDLE);
            finish  <= (nstate == S_DONE);
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed checks of conv_sched at default parameters.
// A cycle-indexed table pins exact outputs of a full-rate pass; an
// independent step-index model checks every cycle of every pass.
module tb_conv_sched;

    logic       clk;
    logic       xrst;
    logic       start;
    logic       enable;
    logic [3:0] w_raddr;
    logic       w_load;
    logic       shift_x;
    logic       shift_y;
    logic       rewind;
    logic [1:0] x;
    logic [1:0] y;
    logic [4:0] X;
    logic [4:0] Y;
    logic       busy;
    logic       finish;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        logic [23:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    conv_sched #(.KSIZE(3), .OSIZE(19), .NW(16)) dut (
        .clk     (clk),
        .xrst    (xrst),
        .start   (start),
        .enable  (enable),
        .w_raddr (w_raddr),
        .w_load  (w_load),
        .shift_x (shift_x),
        .shift_y (shift_y),
        .rewind  (rewind),
        .x       (x),
        .y       (y),
        .X       (X),
        .Y       (Y),
        .busy    (busy),
        .finish  (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input int ra, input int wl, input int kx, input int ky,
                                       input int ox, input int oy, input int sx, input int sy,
                                       input int rw, input int bz, input int fn);
        return {4'(ra), 1'(wl), 2'(kx), 2'(ky), 5'(ox), 5'(oy),
                1'(sx), 1'(sy), 1'(rw), 1'(bz), 1'(fn)};
    endfunction

    function automatic logic [23:0] pack();
        return {w_raddr, w_load, x, y, X, Y, shift_x, shift_y, rewind, busy, finish};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One pass starting from IDLE; cycle k is observed at the negedge after
    // the k-th rising edge following the start request.
    task automatic run_pass(input bit hold, input bit rnd);
        int  phase = 0;
        int  issued = 0;
        int  wl = 0;
        int  idx = 0;
        int  nsx = 0;
        int  nsy = 0;
        int  nrw = 0;
        int  fin_cyc = -1;
        int  ex, ey, eX, eY;
        bit  owed = 1'b0;
        bit  en_l;
        bit  fin_flag = 1'b0;
        start  = 1'b1;
        enable = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 1; k <= 20000 && !fin_flag; k++) begin
            @(negedge clk);
            en_l = enable;
            if (!hold) start = 1'b0;
            if (!rnd) begin
                for (int i = 0; i < NV; i++) begin
                    if (vt[i].cyc == k) check($sformatf("vec_c%0d", k), pack(), vt[i].exp);
                end
            end
            case (phase)
                0: begin
                    check("load_busy", {busy, finish}, 2'b10);
                    check("load_w_load", w_load, owed);
                    check("load_strobes", {shift_x, shift_y, rewind}, 3'b000);
                    if (w_load) wl++;
                    owed = en_l && (issued < 16);
                    if (owed) begin
                        check("load_w_raddr", w_raddr, issued);
                        issued++;
                    end
                    if (wl == 16) phase = 1;
                end
                1: begin
                    ex = idx % 3;
                    ey = (idx / 3) % 3;
                    eX = (idx / 9) % 19;
                    eY = idx / 171;
                    check("run_flags", {busy, finish, w_load}, 3'b100);
                    check("run_counters", {x, y, X, Y}, {2'(ex), 2'(ey), 5'(eX), 5'(eY)});
                    check("run_strobes", {shift_x, shift_y, rewind},
                          {en_l && ex != 2, en_l && ex == 2 && ey != 2, en_l && ex == 2 && ey == 2});
                    nsx += int'(shift_x);
                    nsy += int'(shift_y);
                    nrw += int'(rewind);
                    if (en_l) begin
                        if (idx == 3248) phase = 2;
                        else idx++;
                    end
                end
                2: begin
                    check("done_outputs", pack(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
                    fin_cyc = k;
                    phase = 3;
                end
                default: begin
                    check("idle_after", {busy, finish}, 2'b00);
                    fin_flag = 1'b1;
                end
            endcase
            if (rnd) enable = 1'($urandom_range(0, 1));
        end
        enable = 1'b1;
        if (!fin_flag) check("pass_timeout", phase, 4);
        check("cnt_shift_x", nsx, 2166);
        check("cnt_shift_y", nsy, 722);
        check("cnt_rewind", nrw, 361);
        check("cnt_w_load", wl, 16);
        if (!rnd) check("finish_cycle", fin_cyc, 3267);
    endtask

    initial begin
        vt[0]  = '{1,    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        vt[1]  = '{2,    mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        vt[2]  = '{16,   mk(15, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        vt[3]  = '{17,   mk(15, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        vt[4]  = '{18,   mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
        vt[5]  = '{20,   mk(0, 0, 2, 0, 0, 0, 0, 1, 0, 1, 0)};
        vt[6]  = '{26,   mk(0, 0, 2, 2, 0, 0, 0, 0, 1, 1, 0)};
        vt[7]  = '{27,   mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0)};
        vt[8]  = '{188,  mk(0, 0, 2, 2, 18, 0, 0, 0, 1, 1, 0)};
        vt[9]  = '{189,  mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0)};
        vt[10] = '{594,  mk(0, 0, 0, 0, 7, 3, 1, 0, 0, 1, 0)};
        vt[11] = '{3266, mk(0, 0, 2, 2, 18, 18, 0, 0, 1, 1, 0)};
        vt[12] = '{3267, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
        vt[13] = '{3268, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

        xrst   = 1'b0;
        start  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", pack(), 24'h0);

        // start held through reset release: ignored on the release edge
        start = 1'b1;
        #2 xrst = 1'b1;
        @(negedge clk);
        check("release_edge_busy", busy, 1'b0);
        @(negedge clk);
        check("post_release_busy", busy, 1'b1);
        start = 1'b0;
        #2 xrst = 1'b0;
        #1 check("async_reset_load", pack(), 24'h0);
        @(negedge clk);
        xrst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_before_pass", {busy, finish}, 2'b00);

        // full-rate pass
        run_pass(1'b0, 1'b0);
        @(negedge clk);

        // pseudorandom enable through LOAD and RUN
        run_pass(1'b0, 1'b1);
        @(negedge clk);

        // reset in RUN at X=7, Y=3
        start = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (X == 5'd7 && Y == 5'd3) break;
        end
        check("reach_x7y3", {X, Y}, {5'd7, 5'd3});
        #2 xrst = 1'b0;
        #1 check("async_reset_run", pack(), 24'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_hold", {busy, finish}, 2'b00);
        end
        xrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_restart", {busy, finish}, 2'b00);
        end
        run_pass(1'b0, 1'b0);
        @(negedge clk);

        // start held across a pass: one pass, then a new one from IDLE
        run_pass(1'b1, 1'b0);
        @(negedge clk);
        check("held_start_restart", {busy, w_raddr}, {1'b1, 4'd0});
        start = 1'b0;
        #2 xrst = 1'b0;
        #1 check("final_reset", pack(), 24'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
